// File: rtl/serial_adder_defs.sv
// rtl/serial_adder_defs.sv - shared FSM encodings and counter sizing for serial_adder
package serial_adder_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bit-counter width; never below 1 so the counter stays a legal vector.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/halfadder.sv
// rtl/halfadder.sv - single-bit half adder cell
module halfadder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);

  assign s  = x ^ y;
  assign co = x & y;

endmodule

// File: rtl/serial_adder_full_adder_bit.sv
// rtl/serial_adder_full_adder_bit.sv - full adder built from two half adders plus carry OR
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (.x(x),  .y(y),  .s(s0), .co(c0));
  halfadder u_ha1 (.x(s0), .y(ci), .s(s),  .co(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder
  import serial_adder_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder_bit u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    busy  = (state == ST_SHIFT);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) cout <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed self-checking bench for serial_adder
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the whole operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts, output logic [W-1:0] es, output logic ec);
    int unsigned r;
    if (ts) begin
      es = W'((int'(ta) - int'(tb)) & ((1 << W) - 1));
      ec = (ta >= tb);
    end else begin
      r  = int'(ta) + int'(tb) + int'(tc);
      es = W'(r);
      ec = (r >= (1 << W));
    end
  endtask

  // Issues one add and returns at the negedge where done is observed.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, output realtime tdone);
    logic [W-1:0] es;
    logic         ec;
    int           lat;
    @(negedge clk);
    check({tag, "_ready_pre"}, ready, 1);
    check({tag, "_done_low_pre"}, done, 0);
    a = ta; b = tb; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check({tag, "_busy"}, {busy, ready}, 2'b10);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tdone = $realtime;
    model(ta, tb, tc, ts, es, ec);
    check({tag, "_latency"}, lat, W + 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
  endtask

  initial begin
    realtime t1, t2;
    int d0;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_outs", {ready, busy, done, cout}, 4'b1000);
    check("rst_sum", sum, 0);
    rst = 1'b0;

    run_op("p5a33", 8'h5A, 8'h33, 1'b0, 1'b0, t1);
    run_op("ff01", 8'hFF, 8'h01, 1'b0, 1'b0, t1);
    run_op("ffff1", 8'hFF, 8'hFF, 1'b1, 1'b0, t1);

    // start held high through the operation with a changed mid-flight
    @(negedge clk);
    d0 = done_cnt;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h7F;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    start = 1'b0;
    check("hold_sum", sum, 8'h03);
    check("hold_cout", cout, 0);
    repeat (4) @(negedge clk);
    check("hold_one_done", done_cnt - d0, 1);
    check("hold_idle", ready, 1);

    // reset on the 4th SHIFT edge aborts
    a = 8'h0F; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outs", {ready, busy, done, cout}, 4'b1000);
    check("abort_sum", sum, 0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op("after_abort", 8'h10, 8'h20, 1'b0, 1'b0, t1);

    // back-to-back: second start in first IDLE cycle after done
    run_op("b2b_1", 8'h81, 8'h7F, 1'b0, 1'b0, t1);
    run_op("b2b_2", 8'h44, 8'h11, 1'b1, 1'b0, t2);
    check("b2b_spacing", int'((t2 - t1) / 10.0), W + 2);

    if (SUB_EN) begin
      run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, t1);
      run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, t1);
      run_op("sub0_5a33", 8'h5A, 8'h33, 1'b0, 1'b0, t1);
    end

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      rs = SUB_EN ? 1'($urandom) : 1'b0;
      run_op("rand", ra, rb, rc, rs, t1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // result held through idle cycles
    run_op("hold_res", 8'hC3, 8'h5E, 1'b1, 1'b0, t1);
    repeat (5) @(negedge clk);
    check("held_sum", sum, 8'h22);
    check("held_cout", cout, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
